// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sd;
    logic [WIDTH-1:0] sd_full;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             borrow_next;
    logic             last_bit;

    // One full-subtractor cell; sd_full is the result word including this cycle's bit.
    assign d           = sa[0] ^ sb[0] ^ borrow;
    assign borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    assign sd_full     = {d, sd};
    assign last_bit    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    sd     <= sd_full[WIDTH-1:1];
                    borrow <= borrow_next;
                    cnt    <= cnt + 1'b1;
                    // Results are published only on the DONE-entry edge and hold until the next one.
                    if (last_bit) begin
                        diff <= sd_full;
                        bout <= borrow_next;
                        ovf  <= (a_msb != b_msb) && (d != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - scoreboard bench for serial_sub against an arithmetic reference model
module tb_serial_sub;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           at;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int   cyc;
    int   tests;
    int   fails;
    exp_t q[$];

    serial_sub #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int at);
        exp_t m;
        int   ux;
        int   uy;
        int   s;
        ux   = int'(x);
        uy   = int'(y);
        s    = int'($signed(x)) - int'($signed(y));
        m.d  = W'((ux - uy + (1 << W)) % (1 << W));
        m.bo = (ux < uy);
        m.ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        m.at = at;
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive a start for the next edge and record the expected completion.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1;
        a     = ia;
        b     = ib;
        q.push_back(model(ia, ib, cyc + 1 + W));
        tick();
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.at);
                chk("diff", int'(diff), int'(e.d));
                chk("bout", int'(bout), int'(e.bo));
                chk("ovf", int'(ovf), int'(e.ov));
            end
        end
    end

    initial begin
        int acc0;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        tick();

        // Basic latency and busy window.
        issue(8'd100, 8'd58);
        for (int j = 0; j <= W + 1; j++) begin
            chk("busy_window", int'(busy), (j <= W) ? 1 : 0);
            tick();
        end

        issue(8'd5, 8'd10);    repeat (W + 1) tick();
        issue(8'hFF, 8'hFF);   repeat (W + 1) tick();
        issue(8'h80, 8'h01);   repeat (W + 1) tick();
        issue(8'h7F, 8'hFF);   repeat (W + 1) tick();

        // Start while busy must be ignored; outputs hold afterwards.
        issue(8'd20, 8'd3);
        repeat (3) tick();
        start = 1'b1;
        a     = 8'd1;
        b     = 8'd2;
        tick();
        start = 1'b0;
        repeat (W + 2) tick();
        chk("hold_diff", int'(diff), 17);
        repeat (5) tick();
        chk("hold_diff_later", int'(diff), 17);

        // Reset mid-run aborts without a done pulse.
        start = 1'b1;
        a     = 8'd50;
        b     = 8'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        rst = 1'b0;
        repeat (W + 3) tick();
        issue(8'd30, 8'd12);
        repeat (W + 1) tick();

        // start held high: back-to-back operations every W+2 edges.
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd4;
        acc0  = cyc + 1;
        for (int k = 0; k < 3; k++) q.push_back(model(8'd9, 8'd4, acc0 + k * (W + 2) + W));
        repeat (2 * (W + 2) + 1) tick();
        start = 1'b0;
        repeat (W + 2) tick();

        // Random sweep with junk starts while busy.
        for (int n = 0; n < 200; n++) begin
            issue(W'($urandom), W'($urandom));
            for (int j = 1; j <= W + 1; j++) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                tick();
            end
            start = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end

        for (int t = 0; t < 50 && q.size() > 0; t++) tick();
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d operations never completed, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, using one full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation companion to the team's full-adder arithmetic blocks.
- Trades latency (WIDTH cycles) for a single 1-bit datapath.
- Used where area matters more than throughput.
- Start/busy/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (2 to 32).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on the accepted start edge.
- b, input, WIDTH, subtrahend; captured on the accepted start edge.
- busy, output, 1, high in RUN and DONE states.
- done, output, 1, one-cycle pulse; results valid from this cycle.
- diff, output, WIDTH, registered result a - b modulo 2^WIDTH.
- bout, output, 1, final borrow (1 when a < b unsigned).
- ovf, output, 1, signed (two's complement) overflow of a - b.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state is set to IDLE.
  - busy, done, bout and ovf are set to 0; diff is set to 0.
  - Internal shift registers, borrow FF and bit counter are cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge k: load sa=a, sb=b, borrow=0, cnt=0, latch a[WIDTH-1] and b[WIDTH-1]; go to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - d = sa[0] ^ sb[0] ^ borrow.
  - borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow).
  - Shift sa and sb right by one; shift d into the MSB of internal shift register sd; cnt increments.
- RUN termination: on the edge processing bit WIDTH-1 (edge k+WIDTH):
  - Go to DONE.
  - Copy the full sd (including the final d) to diff.
  - bout = borrow_next.
  - ovf = (a_msb != b_msb) & (d != a_msb), where d is the result MSB.
- DONE:
  - done=1 for exactly one cycle (cycle after edge k+WIDTH); go to IDLE at the next edge.
- Latency: done is high WIDTH+1 cycles after the start edge. Throughput: one operation per WIDTH+2 cycles.
- diff, bout and ovf change only on the DONE-entry edge or reset; they hold until the next completion. A new start does not clear them.
- start asserted while busy (RUN or DONE) is ignored and not queued. a and b may change freely after capture.
- start held high continuously: a new operation is accepted in each IDLE cycle (back-to-back at WIDTH+2 spacing).
- The counter is width-safe for WIDTH up to 32. No wrap is possible; cnt is cleared on each load.

Test Plan:
- WIDTH=8, a=100, b=58, start pulse at edge k → done high exactly in cycle k+9; diff=42, bout=0, ovf=0; busy high cycles k+1..k+9.
- a=8'd5, b=8'd10 → diff=8'hFB, bout=1, ovf=0; a=8'hFF, b=8'hFF → diff=0, bout=0, ovf=0.
- a=8'h80, b=8'h01 → diff=8'h7F, bout=0, ovf=1; a=8'h7F, b=8'hFF → diff=8'h80, bout=1, ovf=1.
- Start with a=20, b=3, then pulse start with a=1, b=2 at cycle k+4 → ignored; single done with diff=17; outputs hold 17 until the next completion.
- Assert rst in cycle k+5 of an operation → next cycle busy=0, done=0, diff=0; no done pulse; a fresh start then completes normally.
- start held high with constant a=9, b=4 → done pulses every 10 cycles, diff=5 each time; random 200-vector sweep versus a reference model checking diff, bout and ovf.
